// File: rtl/fir_pkg.sv
// Shared constants and the signed saturation helper for the FIR output chain.
package fir_pkg;

   localparam int unsigned FIR_W     = 16;
   localparam int unsigned OUT_W_DEF = 8;

   // Clamp a 17-bit signed value into the signed range of a width-bit word.
   function automatic logic signed [FIR_W:0] sat_s(input logic signed [FIR_W:0] value,
                                                   input int unsigned           width);
      logic signed [FIR_W:0] hi;
      logic signed [FIR_W:0] lo;
      hi = signed'((FIR_W + 1)'((32'd1 << (width - 1)) - 32'd1));
      lo = ~hi;
      if (value > hi) begin
         return hi;
      end else if (value < lo) begin
         return lo;
      end
      return value;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a registered head word that holds its last value when empty.
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_q, rd_q, rd_nxt;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] head_q;
   logic             do_push, do_pop;

   assign empty   = (cnt_q == '0);
   assign full    = (cnt_q == CW'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rd_nxt  = rd_q + AW'(1);
   assign rdata   = head_q;
   assign count   = cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
         wr_q   <= '0;
         rd_q   <= '0;
         cnt_q  <= '0;
         head_q <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_q] <= wdata;
            wr_q        <= wr_q + AW'(1);
         end
         if (do_pop) begin
            rd_q <= rd_nxt;
         end
         case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + CW'(1);
            2'b01:   cnt_q <= cnt_q - CW'(1);
            default: cnt_q <= cnt_q;
         endcase
         // Head comes from storage if another entry remains, else straight from the write port.
         if (do_pop && (cnt_q > CW'(1))) begin
            head_q <= mem_q[rd_nxt];
         end else if (do_push && (empty || do_pop)) begin
            head_q <= wdata;
         end
      end
   end

endmodule

// File: rtl/fir_decim.sv
// Warm-up discard, decimation, scale/saturate and FIFO buffering of the FIR output.
// Optional rounding before the shift is enabled by defining FIR_DECIM_ROUND_EN.
module fir_decim
   import fir_pkg::*;
#(
   parameter int unsigned DECIM  = 4,
   parameter int unsigned SHIFT  = 1,
   parameter int unsigned OUT_W  = OUT_W_DEF,
   parameter int unsigned DEPTH  = 8,
   parameter int unsigned WARMUP = 14
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic signed [FIR_W-1:0]  y,
   input  logic                     clr,
   output logic signed [OUT_W-1:0]  out_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     sat,
   output logic                     ovf
);
   localparam int unsigned WCW = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
   localparam int unsigned PCW = (DECIM > 1) ? $clog2(DECIM) : 1;

   logic [WCW-1:0]        warm_q;
   logic [PCW-1:0]        phase_q;
   logic                  active, take, keep, drop, pop, full, empty, clipped;
   logic                  sat_q, ovf_q;
   logic [OUT_W-1:0]      fifo_rdata;
   logic signed [FIR_W:0] ext, scaled, clamped;

   assign active = (warm_q == WCW'(WARMUP));
   assign take   = active && (phase_q == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         warm_q  <= '0;
         phase_q <= '0;
      end else if (!active) begin
         warm_q <= warm_q + WCW'(1);
      end else begin
         phase_q <= (phase_q == PCW'(DECIM - 1)) ? '0 : phase_q + PCW'(1);
      end
   end

`ifdef FIR_DECIM_ROUND_EN
   localparam logic signed [FIR_W:0] RND = (FIR_W + 1)'((32'd1 << SHIFT) >> 1);
`endif

   always_comb begin
      ext = {y[FIR_W-1], y};
`ifdef FIR_DECIM_ROUND_EN
      ext = ext + RND;
`endif
      scaled  = ext >>> SHIFT;
      clamped = sat_s(scaled, OUT_W);
      clipped = (clamped != scaled);
   end

   assign pop       = out_valid && out_ready;
   assign drop      = take && full && !pop;
   assign keep      = take && !drop;
   assign out_valid = !empty;
   assign out_data  = signed'(fifo_rdata);
   assign sat       = sat_q;
   assign ovf       = ovf_q;

   sync_fifo #(
      .WIDTH (OUT_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (take),
      .wdata (clamped[OUT_W-1:0]),
      .pop   (pop),
      .rdata (fifo_rdata),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   // A set event in the same cycle as clr takes priority.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sat_q <= 1'b0;
         ovf_q <= 1'b0;
      end else begin
         if (keep && clipped) begin
            sat_q <= 1'b1;
         end else if (clr) begin
            sat_q <= 1'b0;
         end
         if (drop) begin
            ovf_q <= 1'b1;
         end else if (clr) begin
            ovf_q <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fir_decim.sv
// Self-checking bench for fir_decim: queue-based reference model plus directed vectors.
module tb_fir_decim;

   localparam int DECIM  = 4;
   localparam int SHIFT  = 1;
   localparam int OUT_W  = 8;
   localparam int DEPTH  = 8;
   localparam int WARMUP = 14;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] y = '0;
   logic        clr = 1'b0;
   logic        out_ready = 1'b1;
   logic [7:0]  out_data;
   logic        out_valid;
   logic [3:0]  count;
   logic        sat;
   logic        ovf;

   fir_decim #(
      .DECIM  (DECIM),
      .SHIFT  (SHIFT),
      .OUT_W  (OUT_W),
      .DEPTH  (DEPTH),
      .WARMUP (WARMUP)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .y         (y),
      .clr       (clr),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .count     (count),
      .sat       (sat),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;

   // Reference model state: samples seen since release, FIFO contents, visible head, flags.
   int n;
   int mq[$];
   int last_head;
   bit m_sat, m_ovf;

   typedef struct {
      logic [15:0] y;
      int          exp_data;
      bit          exp_sat;
   } vec_t;
   vec_t vecs[8];

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void scale(input logic [15:0] yy, output int v, output bit clip);
      int t, hi, lo;
      t = int'(signed'(yy));
`ifdef FIR_DECIM_ROUND_EN
      t = t + ((1 << SHIFT) >> 1);
`endif
      t  = t >>> SHIFT;
      hi = (1 << (OUT_W - 1)) - 1;
      lo = -(1 << (OUT_W - 1));
      clip = (t > hi) || (t < lo);
      v = (t > hi) ? hi : ((t < lo) ? lo : t);
   endfunction

   function automatic bit take_now();
      return (n >= WARMUP) && (((n - WARMUP) % DECIM) == 0);
   endfunction

   task automatic model_reset();
      n = 0;
      mq.delete();
      last_head = 0;
      m_sat = 1'b0;
      m_ovf = 1'b0;
   endtask

   task automatic model_edge();
      bit take, pop, clip, set_sat, set_ovf;
      int v;
      take = take_now();
      pop  = (mq.size() > 0) && out_ready;
      scale(y, v, clip);
      set_sat = 1'b0;
      set_ovf = 1'b0;
      if (pop) void'(mq.pop_front());
      if (take) begin
         if (mq.size() < DEPTH) begin
            mq.push_back(v);
            set_sat = clip;
         end else begin
            set_ovf = 1'b1;
         end
      end
      if (clr) begin
         m_sat = 1'b0;
         m_ovf = 1'b0;
      end
      if (set_sat) m_sat = 1'b1;
      if (set_ovf) m_ovf = 1'b1;
      if (mq.size() > 0) last_head = mq[0];
      n++;
   endtask

   task automatic check_all();
      chk("out_valid", int'(out_valid), (mq.size() > 0) ? 1 : 0);
      chk("count", int'(count), mq.size());
      chk("out_data", int'(out_data), last_head & 255);
      chk("sat", int'(sat), int'(m_sat));
      chk("ovf", int'(ovf), int'(m_ovf));
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic goto_take(input bit want);
      for (int i = 0; i < DECIM + 1; i++) begin
         if (take_now() == want) break;
         step();
      end
   endtask

   task automatic run_ramp();
      int first;
      int got[$];
      first = -1;
      out_ready = 1'b1;
      clr = 1'b0;
      for (int k = 0; k < 32; k++) begin
         y = 16'(k);
         step();
         if (out_valid) begin
            if (first < 0) first = k + 1;
            got.push_back(int'(out_data));
         end
      end
      chk("ramp_first_push_edge", first, WARMUP + 1);
      chk("ramp_enough_pushes", (got.size() >= 3) ? 1 : 0, 1);
      if (got.size() >= 3) begin
         chk("ramp_val0", got[0], 7);
         chk("ramp_val1", got[1], 9);
         chk("ramp_val2", got[2], 11);
      end
   endtask

   initial begin
      int takes;
      int exp_q[$];

      vecs[0] = '{16'h0005, 2, 1'b0};
      vecs[1] = '{16'h00FF, 8'h7F, 1'b0};
      vecs[2] = '{16'h0100, 8'h7F, 1'b1};
      vecs[3] = '{16'hFF00, 8'h80, 1'b0};
      vecs[4] = '{16'hFE00, 8'h80, 1'b1};
      vecs[5] = '{16'hFFFF, 8'hFF, 1'b0};
      vecs[6] = '{16'h00F0, 8'h78, 1'b0};
      vecs[7] = '{16'hFFF5, 8'hFA, 1'b0};
`ifdef FIR_DECIM_ROUND_EN
      vecs[0].exp_data = 3;
      vecs[1].exp_sat  = 1'b1;
      vecs[5].exp_data = 8'h00;
      vecs[7].exp_data = 8'hFB;
`endif

      // Reset state
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_all();
      chk("rst_out_data", int'(out_data), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();

      // Warm-up and ramp decimation
      run_ramp();

      // Scaling and saturation table
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         y = vecs[i].y;
         clr = 1'b1;
         step();
         clr = 1'b0;
         repeat (DECIM - 1) step();
         chk($sformatf("scale_data[%0d]", i), int'(out_data), vecs[i].exp_data);
         chk($sformatf("scale_sat[%0d]", i), int'(sat), int'(vecs[i].exp_sat));
      end

      // Empty the FIFO with the next cycle a non-take one, flags cleared
      y = 16'h0010;
      out_ready = 1'b1;
      goto_take(1'b1);
      clr = 1'b1;
      step();
      clr = 1'b0;
      step();

      // Backpressure: fill to DEPTH, ninth decimated sample dropped
      out_ready = 1'b0;
      takes = 0;
      for (int i = 0; i < 12 * DECIM && takes < 9; i++) begin
         y = 16'(3 * i + 1);
         if (take_now()) takes++;
         step();
      end
      chk("bp_count_full", int'(count), DEPTH);
      chk("bp_ovf", int'(ovf), 1);

      // clr with no event clears ovf
      goto_take(1'b0);
      clr = 1'b1;
      step();
      clr = 1'b0;
      chk("clr_ovf", int'(ovf), 0);

      // Full FIFO, push and pop in the same cycle
      goto_take(1'b1);
      y = 16'h0033;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("full_pushpop_count", int'(count), DEPTH);
      chk("full_pushpop_ovf", int'(ovf), 0);

      // Drain in order
      exp_q = mq;
      out_ready = 1'b1;
      for (int j = 0; j < DEPTH; j++) begin
         chk($sformatf("drain[%0d]", j), int'(out_data), exp_q[j] & 255);
         step();
      end

      // clr coincident with a saturating push: set wins
      y = 16'h0100;
      goto_take(1'b0);
      clr = 1'b1;
      step();
      clr = 1'b0;
      chk("clr_sat", int'(sat), 0);
      goto_take(1'b1);
      clr = 1'b1;
      step();
      clr = 1'b0;
      chk("clr_vs_set_sat", int'(sat), 1);

      // Mid-stream asynchronous reset with five entries queued
      out_ready = 1'b0;
      for (int i = 0; i < 40 && mq.size() < 5; i++) step();
      chk("pre_rst_count", int'(count), 5);
      #3;
      rst_n = 1'b0;
      model_reset();
      #1;
      check_all();
      chk("async_rst_valid", int'(out_valid), 0);
      chk("async_rst_count", int'(count), 0);
      chk("async_rst_sat", int'(sat), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
      run_ramp();

      // Randomized traffic against the model
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 1) == 0) y = 16'($urandom);
         else y = 16'(int'($urandom_range(0, 600)) - 300);
         out_ready = ($urandom_range(0, 3) != 0) || (i % 100 < 20 ? 1'b0 : 1'b0);
         if ((i % 200) >= 150) out_ready = 1'b0;
         clr = ($urandom_range(0, 15) == 0);
         step();
      end
      clr = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
